// File: rtl/dnn_stream_host.sv
// Stream host: sends a batch of source words to the accelerator, then collects its results.
// Latency: first src word 2 cycles after start, then 1 word/cycle; hrd has 1-cycle read latency.
// Backpressure: src_data/src_last hold while src_ready is low; dst_ready follows !sink_stall in RECV.
//
// Ports: clk/reset (sync, active-high); start/src_len/dst_len begin a batch;
// hwe/hwa/hwd load the source memory; hra/hrd read the result memory;
// run/busy/done/err status; src_* source stream out; dst_* result stream in.
module dnn_stream_host #(
    parameter int DEPTH = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] src_len,
    input  logic [11:0] dst_len,
    input  logic        sink_stall,
    input  logic        hwe,
    input  logic [11:0] hwa,
    input  real         hwd,
    input  logic [11:0] hra,
    output real         hrd,
    output logic        run,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        src_valid,
    output real         src_data,
    output logic        src_last,
    input  logic        src_ready,
    input  logic        dst_valid,
    input  real         dst_data,
    input  logic        dst_last,
    output logic        dst_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RECV,
        ST_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] src_len_q;
    logic [11:0] dst_len_q;
    logic [11:0] scnt;
    logic [11:0] dcnt;
    logic [11:0] scnt_inc;
    logic        idle_or_done;
    logic        start_ok;
    logic        src_xfer;
    logic        dst_xfer;

    real src_mem [DEPTH];
    real res_mem [DEPTH];

    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    assign start_ok     = start && idle_or_done;
    assign src_xfer     = src_valid && src_ready;
    assign dst_xfer     = dst_valid && dst_ready;
    assign scnt_inc     = scnt + 12'd1;

    assign busy      = (state == ST_SEND) || (state == ST_RECV);
    assign run       = busy;
    assign done      = (state == ST_DONE);
    assign dst_ready = (state == ST_RECV) && !sink_stall;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_SEND;
            ST_SEND:          if (src_xfer && src_last) state_nxt = ST_RECV;
            ST_RECV:          if (dst_xfer && (dcnt == dst_len_q)) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // The src_data register doubles as the source memory's read register:
    // on a transfer it is loaded with word scnt+1 directly, so there is no
    // bubble between beats while src_ready stays high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            src_len_q <= 12'd0;
            dst_len_q <= 12'd0;
            scnt      <= 12'd0;
            dcnt      <= 12'd0;
            err       <= 1'b0;
            src_valid <= 1'b0;
            src_last  <= 1'b0;
            src_data  <= 0.0;
            hrd       <= 0.0;
        end else begin
            state <= state_nxt;
            hrd   <= res_mem[hra];
            if (start_ok) begin
                src_len_q <= src_len;
                dst_len_q <= dst_len;
                scnt      <= 12'd0;
                dcnt      <= 12'd0;
                err       <= 1'b0;
                src_valid <= 1'b0;
                src_last  <= 1'b0;
            end else if (state == ST_SEND) begin
                if (!src_valid) begin
                    // first word of the batch; read issued the cycle after start
                    src_valid <= 1'b1;
                    src_data  <= src_mem[scnt];
                    src_last  <= (scnt == src_len_q);
                end else if (src_xfer) begin
                    if (src_last) begin
                        src_valid <= 1'b0;
                        src_last  <= 1'b0;
                    end else begin
                        scnt     <= scnt_inc;
                        src_data <= src_mem[scnt_inc];
                        src_last <= (scnt_inc == src_len_q);
                    end
                end
            end else if (state == ST_RECV) begin
                if (dst_xfer) begin
                    dcnt <= dcnt + 12'd1;
                    // completion is by count; a misplaced dst_last only flags err
                    if (dst_last != (dcnt == dst_len_q)) err <= 1'b1;
                end
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (hwe && idle_or_done) src_mem[hwa] <= hwd;
        if (dst_xfer) res_mem[dcnt] <= dst_data;
    end

endmodule

// File: tb/tb_dnn_stream_host.sv
module tb_dnn_stream_host;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] src_len = 12'd0;
    logic [11:0] dst_len = 12'd0;
    logic        sink_stall = 1'b0;
    logic        hwe = 1'b0;
    logic [11:0] hwa = 12'd0;
    real         hwd = 0.0;
    logic [11:0] hra = 12'd0;
    real         hrd;
    logic        run, busy, done, err;
    logic        src_valid, src_last;
    real         src_data;
    logic        src_ready = 1'b1;
    logic        dst_valid = 1'b0;
    real         dst_data = 0.0;
    logic        dst_last = 1'b0;
    logic        dst_ready;

    dnn_stream_host #(.DEPTH(4096)) dut (
        .clk(clk), .reset(reset), .start(start), .src_len(src_len), .dst_len(dst_len),
        .sink_stall(sink_stall), .hwe(hwe), .hwa(hwa), .hwd(hwd), .hra(hra), .hrd(hrd),
        .run(run), .busy(busy), .done(done), .err(err),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
        .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last), .dst_ready(dst_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // behavioural model: source memory image, result image, batch progress
    real src_model [4096];
    real res_model [4096];
    bit  m_send = 0, m_recv = 0, m_done = 0, m_err = 0;
    int  m_sidx = 0, m_slen = 0, m_didx = 0, m_dlen = 0;
    int  m_sbeats = 0, m_dbeats = 0, m_wait = 0;
    real last_src = 0.0;
    bit  last_flag_seen = 0;
    bit  prev_hold = 0, prev_xfer = 0;
    real prev_dat = 0.0;

    // sink reply queue
    real rq_dat [$];
    bit  rq_last [$];

    bit       ready_mode = 0;
    bit [3:0] ready_pat = 4'b1001;  // 1,0,0,1 from bit 0 upward
    int       cyc = 0;

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_real(input string nm, input real act, input real exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %f want %f at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        src_ready = ready_mode ? ready_pat[cyc % 4] : 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (rq_dat.size() > 0) begin
            dst_valid = 1'b1;
            dst_data  = rq_dat[0];
            dst_last  = rq_last[0];
        end else begin
            dst_valid = 1'b0;
            dst_data  = 0.0;
            dst_last  = 1'b0;
        end
    end

    // compare process: every cycle out of reset
    always @(negedge clk) begin
        if (!reset) begin
            chk_bit("busy", busy, m_send | m_recv);
            chk_bit("run", run, m_send | m_recv);
            chk_bit("done", done, m_done);
            chk_bit("err", err, m_err);
            chk_bit("dst_ready", dst_ready, m_recv & !sink_stall);
            if (prev_hold) begin
                chk_bit("src_hold_valid", src_valid, 1'b1);
                chk_real("src_hold_data", src_data, prev_dat);
            end
            if (prev_xfer && src_ready) chk_bit("src_gap", src_valid, 1'b1);
            if (src_valid) begin
                if (!m_send) begin
                    chk_bit("src_valid_spurious", src_valid, 1'b0);
                end else begin
                    chk_real("src_data", src_data, src_model[m_sidx]);
                    chk_bit("src_last", src_last, m_sidx == m_slen);
                    if (src_ready) begin
                        m_sbeats++;
                        last_src = src_data;
                        if (src_last) last_flag_seen = 1;
                        if (m_sidx == m_slen) begin
                            m_send = 0;
                            m_recv = 1;
                        end else begin
                            m_sidx++;
                        end
                    end
                end
            end else if (m_send && m_sidx == 0) begin
                m_wait++;
                if (m_wait > 1) chk_bit("src_valid_late", src_valid, 1'b1);
            end
            prev_hold = src_valid & !src_ready;
            prev_xfer = src_valid & src_ready & !src_last;
            prev_dat  = src_data;
            if (dst_valid && dst_ready) begin
                res_model[m_didx] = dst_data;
                if (dst_last != (m_didx == m_dlen)) m_err = 1;
                if (rq_dat.size() > 0) begin
                    void'(rq_dat.pop_front());
                    void'(rq_last.pop_front());
                end
                m_dbeats++;
                if (m_didx == m_dlen) begin
                    m_recv = 0;
                    m_done = 1;
                end
                m_didx++;
            end
        end
    end

    task automatic host_write(input int a, input real d, input bit honoured);
        @(posedge clk); #1;
        hwe = 1'b1; hwa = 12'(a); hwd = d;
        @(posedge clk); #1;
        hwe = 1'b0;
        if (honoured) src_model[a] = d;
    endtask

    task automatic do_start(input int sl, input int dl);
        @(posedge clk); #1;
        start = 1'b1; src_len = 12'(sl); dst_len = 12'(dl);
        @(posedge clk); #1;
        start = 1'b0;
        m_send = 1; m_recv = 0; m_done = 0; m_err = 0;
        m_sidx = 0; m_slen = sl; m_didx = 0; m_dlen = dl;
        m_sbeats = 0; m_dbeats = 0; m_wait = 0; last_flag_seen = 0;
        prev_hold = 0; prev_xfer = 0;
    endtask

    // start pulse that the bench expects the DUT to ignore (model untouched)
    task automatic pulse_start_busy();
        @(posedge clk); #1;
        start = 1'b1; src_len = 12'd2; dst_len = 12'd1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (n < budget && !(done === 1'b1)) begin
            @(negedge clk);
            n++;
        end
        chk_bit("done_within_budget", done, 1'b1);
    endtask

    task automatic read_res(input int a, input real exp_lit);
        @(posedge clk); #1;
        hra = 12'(a);
        @(posedge clk); #1;
        chk_real("hrd_model", hrd, res_model[a]);
        chk_real("hrd_literal", hrd, exp_lit);
    endtask

    task automatic push_reply(input real d, input bit l);
        rq_dat.push_back(d);
        rq_last.push_back(l);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_bit("rst_src_valid", src_valid, 1'b0);
        chk_bit("rst_src_last", src_last, 1'b0);
        chk_real("rst_src_data", src_data, 0.0);
        chk_real("rst_hrd", hrd, 0.0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_dst_ready", dst_ready, 1'b0);
        reset = 1'b0;

        // basic batch
        for (int i = 0; i < 10; i++) host_write(i, real'(i), 1);
        for (int i = 0; i < 4; i++) push_reply(1.5 + real'(i), i == 3);
        do_start(9, 3);
        wait_done(200);
        chk_int("basic_src_beats", m_sbeats, 10);
        chk_real("basic_last_word", last_src, 9.0);
        chk_bit("basic_err", err, 1'b0);
        for (int i = 0; i < 4; i++) read_res(i, 1.5 + real'(i));

        // src back-pressure, plus hazards: host write and start while busy
        ready_mode = 1;
        push_reply(7.0, 1);
        do_start(9, 0);
        host_write(8, 99.0, 0);
        pulse_start_busy();
        wait_done(300);
        ready_mode = 0;
        chk_int("bp_src_beats", m_sbeats, 10);
        chk_real("bp_last_word", last_src, 9.0);
        read_res(0, 7.0);

        // sink stall mid-RECV
        for (int i = 0; i < 8; i++) push_reply(10.0 + real'(i), i == 7);
        do_start(3, 7);
        begin
            int n;
            n = 0;
            while (m_didx < 2 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk_bit("stall_reach_recv", (m_didx >= 2), 1'b1);
        end
        @(posedge clk); #1;
        sink_stall = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        sink_stall = 1'b0;
        wait_done(200);
        chk_int("stall_dst_beats", m_dbeats, 8);
        for (int i = 0; i < 8; i++) read_res(i, 10.0 + real'(i));

        // dst_last on beat 2 of 4
        for (int i = 0; i < 4; i++) push_reply(20.0 + real'(i), i == 1);
        do_start(0, 3);
        wait_done(200);
        chk_bit("mismatch_err", err, 1'b1);
        chk_int("mismatch_dst_beats", m_dbeats, 4);
        read_res(3, 23.0);

        // single-beat batch; also clears err
        push_reply(30.0, 1);
        do_start(0, 0);
        wait_done(200);
        chk_bit("restart_err_clear", err, 1'b0);
        chk_int("len0_src_beats", m_sbeats, 1);
        chk_bit("len0_last_seen", last_flag_seen, 1'b1);
        chk_real("len0_word", last_src, 0.0);

        // full-depth batch
        for (int i = 0; i < 4096; i++) host_write(i, real'(i) * 0.5 + 0.25, 1);
        push_reply(40.0, 1);
        do_start(4095, 0);
        wait_done(6000);
        chk_int("full_src_beats", m_sbeats, 4096);
        chk_real("full_last_word", last_src, 4095.0 * 0.5 + 0.25);
        chk_bit("full_last_seen", last_flag_seen, 1'b1);

        // reset mid-SEND
        do_start(20, 0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_send = 0; m_recv = 0; m_done = 0; m_err = 0;
        prev_hold = 0; prev_xfer = 0;
        chk_bit("rstmid_src_valid", src_valid, 1'b0);
        chk_bit("rstmid_busy", busy, 1'b0);
        chk_bit("rstmid_done", done, 1'b0);
        chk_real("rstmid_hrd", hrd, 0.0);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
